// File: rtl/bp_pkg.sv
// Shared constants, encodings and the PHT counter update for the branch predictor
// update path.
package bp_pkg;

  localparam int BTB_DEPTH   = 1024;
  localparam int PHT_DEPTH   = 256;
  localparam int BTB_IDX_W   = 10;
  localparam int PHT_IDX_W   = 8;
  localparam int GHR_W       = 8;
  localparam int BTB_ENTRY_W = 66;

  localparam int BTB_VALID_BIT = 65;
  localparam int BTB_TYPE_BIT  = 64;
  localparam int BTB_ADDR_MSB  = 63;
  localparam int BTB_ADDR_LSB  = 32;
  localparam int BTB_TGT_MSB   = 31;
  localparam int BTB_TGT_LSB   = 0;

  typedef enum logic [1:0] {
    PHT_SNT = 2'd0,
    PHT_WNT = 2'd1,
    PHT_WT  = 2'd2,
    PHT_ST  = 2'd3
  } pht_state_e;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_e;

  function automatic logic [1:0] pht_sat_update(input logic [1:0] old, input logic taken);
    logic [1:0] nxt;
    nxt = old;
    if (taken) begin
      if (old != PHT_ST) nxt = old + 2'd1;
      else               nxt = old;
    end else begin
      if (old != PHT_SNT) nxt = old - 2'd1;
      else                nxt = old;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sweep_cnt.sv
// Invalidation sweep counter: counts 0..BTB_DEPTH-1 once, then holds with the
// done bit set until restarted.
module bp_sweep_cnt
  import bp_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_restart,
  output logic [BTB_IDX_W-1:0] o_cnt,
  output logic                 o_last
);

  logic [BTB_IDX_W:0] r_cnt;

  // Sweep index; the extra MSB is the done flag that freezes the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en && !r_cnt[BTB_IDX_W]) begin
      r_cnt <= r_cnt + (BTB_IDX_W+1)'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt[BTB_IDX_W-1:0];
  assign o_last = (r_cnt == (BTB_IDX_W+1)'(BTB_DEPTH - 1));

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor table write sequencer: post-reset/on-demand invalidation sweep,
// GHR ownership, and a 2-stage PHT read-modify-write with same-index forwarding.
module bp_update_ctrl
  import bp_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr_req,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [31:0]            upd_pc,
  input  logic                   upd_cond,
  input  logic                   upd_taken,
  input  logic [31:0]            upd_target,
  output logic                   btb_we,
  output logic [BTB_IDX_W-1:0]   btb_waddr,
  output logic [BTB_ENTRY_W-1:0] btb_wdata,
  output logic                   pht_re,
  output logic [PHT_IDX_W-1:0]   pht_raddr,
  input  logic [1:0]             pht_rdata,
  output logic                   pht_we,
  output logic [PHT_IDX_W-1:0]   pht_waddr,
  output logic [1:0]             pht_wdata,
  output logic [GHR_W-1:0]       ghr,
  output logic                   busy
);

  ctrl_state_e          r_state;
  logic [GHR_W-1:0]     r_ghr;
  logic                 r_s1_valid;
  logic                 r_s1_cond;
  logic                 r_s1_taken;
  logic [31:0]          r_s1_pc;
  logic [31:0]          r_s1_target;
  logic [PHT_IDX_W-1:0] r_s1_idx;
  logic                 r_fwd_hit;
  logic [1:0]           r_fwd_data;

  logic [BTB_IDX_W-1:0] w_cnt;
  logic                 w_last;
  logic                 w_accept;
  logic [PHT_IDX_W-1:0] w_pht_idx;
  logic [1:0]           w_old;
  logic [1:0]           w_new;

  bp_sweep_cnt u_sweep_cnt (
    .i_clk     (clk),
    .i_rst_n   (resetn),
    .i_en      (r_state == ST_SWEEP),
    .i_restart (clr_req),
    .o_cnt     (w_cnt),
    .o_last    (w_last)
  );

  assign upd_ready = (r_state == ST_RUN) && !clr_req;
  assign w_accept  = upd_valid && upd_ready;
  assign w_pht_idx = r_ghr ^ upd_pc[9:2];
  assign pht_re    = w_accept && upd_cond;
  assign pht_raddr = w_pht_idx;
  // The RAM cannot see the write landing in the same cycle as its read.
  assign w_old     = r_fwd_hit ? r_fwd_data : pht_rdata;
  assign w_new     = pht_sat_update(w_old, r_s1_taken);
  assign ghr       = r_ghr;
  assign busy      = (r_state == ST_SWEEP);

  // Table write port mux: sweep clears, otherwise the S1 stage retires its update.
  always_comb begin
    btb_we    = 1'b0;
    btb_waddr = '0;
    btb_wdata = '0;
    pht_we    = 1'b0;
    pht_waddr = '0;
    pht_wdata = 2'b00;
    if (!resetn) begin
      btb_we = 1'b0;
    end else if (r_state == ST_SWEEP) begin
      btb_we    = 1'b1;
      btb_waddr = w_cnt;
      pht_we    = (w_cnt < BTB_IDX_W'(PHT_DEPTH));
      pht_waddr = w_cnt[PHT_IDX_W-1:0];
    end else if (r_s1_valid) begin
      btb_we    = 1'b1;
      btb_waddr = r_s1_pc[11:2];
      btb_wdata = {1'b1, r_s1_cond, r_s1_pc, r_s1_target};
      pht_we    = r_s1_cond;
      pht_waddr = r_s1_idx;
      pht_wdata = w_new;
    end else begin
      btb_we = 1'b0;
    end
  end

  // Control FSM, GHR and the S1 update stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_SWEEP;
      r_ghr       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_cond   <= 1'b0;
      r_s1_taken  <= 1'b0;
      r_s1_pc     <= '0;
      r_s1_target <= '0;
      r_s1_idx    <= '0;
      r_fwd_hit   <= 1'b0;
      r_fwd_data  <= 2'b00;
    end else begin
      r_s1_valid <= w_accept;
      r_fwd_hit  <= w_accept && upd_cond && r_s1_valid && r_s1_cond && (w_pht_idx == r_s1_idx);
      r_fwd_data <= w_new;
      if (w_accept) begin
        r_s1_cond   <= upd_cond;
        r_s1_taken  <= upd_taken;
        r_s1_pc     <= upd_pc;
        r_s1_target <= upd_target;
        r_s1_idx    <= w_pht_idx;
      end
      if (clr_req) begin
        r_state <= ST_SWEEP;
        r_ghr   <= '0;
      end else begin
        if (w_accept && upd_cond) r_ghr <= {r_ghr[GHR_W-2:0], upd_taken};
        case (r_state)
          ST_SWEEP: if (w_last) r_state <= ST_RUN;
          ST_RUN:   r_state <= ST_RUN;
          default:  r_state <= ST_SWEEP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a table-level reference model queues the
// expected table writes; a monitor pops and compares whenever the DUT writes.
module tb_bp_update_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clr_req = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_cond = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic [31:0] upd_target = 32'd0;
  logic        upd_ready;
  logic        btb_we;
  logic [9:0]  btb_waddr;
  logic [65:0] btb_wdata;
  logic        pht_re;
  logic [7:0]  pht_raddr;
  logic [1:0]  pht_rdata = 2'b00;
  logic        pht_we;
  logic [7:0]  pht_waddr;
  logic [1:0]  pht_wdata;
  logic [7:0]  ghr;
  logic        busy;

  bp_update_ctrl dut (
    .clk(clk), .resetn(resetn), .clr_req(clr_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_cond(upd_cond), .upd_taken(upd_taken), .upd_target(upd_target),
    .btb_we(btb_we), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
    .pht_re(pht_re), .pht_raddr(pht_raddr), .pht_rdata(pht_rdata),
    .pht_we(pht_we), .pht_waddr(pht_waddr), .pht_wdata(pht_wdata),
    .ghr(ghr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read PHT RAM plus a bench-side preload port.
  logic [1:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [1:0] pl_data = 2'b00;
  always @(posedge clk) begin
    if (pht_re) pht_rdata <= mem[pht_raddr];
    if (pht_we) mem[pht_waddr] <= pht_wdata;
    if (pl_en)  mem[pl_addr] <= pl_data;
  end

  typedef struct {
    logic [9:0]  btb_addr;
    logic [65:0] btb_data;
    logic        pht_we;
    logic [7:0]  pht_addr;
    logic [1:0]  pht_data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] ref_ghr = 8'd0;
  logic       ref_run = 1'b0;
  int         sweep_n = 0;
  logic [1:0] ref_pht [256];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // A sweep clears every table entry; queue its 1024 BTB writes (first 256 also PHT).
  task automatic start_sweep();
    exp_t e;
    for (int k = 0; k < 1024; k++) begin
      e.btb_addr = 10'(k);
      e.btb_data = 66'd0;
      e.pht_we   = (k < 256);
      e.pht_addr = 8'(k);
      e.pht_data = 2'b00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 256; i++) ref_pht[i] = 2'b00;
    ref_run = 1'b0;
    sweep_n = 0;
  endtask

  // One cycle: drive, check cycle-T outputs at negedge, update the model, advance.
  task automatic cyc(input logic v, input logic c, input logic t,
                     input logic [31:0] pc, input logic [31:0] tg, input logic clr);
    exp_t       e;
    logic [7:0] idx;
    logic       ready_e;
    int         cnt;
    upd_valid = v; upd_cond = c; upd_taken = t;
    upd_pc = pc; upd_target = tg; clr_req = clr;
    @(negedge clk);
    ready_e = ref_run && !clr;
    chk("upd_ready", 66'(upd_ready), 66'(ready_e));
    chk("busy", 66'(busy), 66'(!ref_run));
    chk("ghr", 66'(ghr), 66'(ref_ghr));
    if (v && ready_e) begin
      idx = ref_ghr ^ pc[9:2];
      chk("pht_re", 66'(pht_re), 66'(c));
      if (c) chk("pht_raddr", 66'(pht_raddr), 66'(idx));
      e.btb_addr = pc[11:2];
      e.btb_data = {1'b1, c, pc, tg};
      e.pht_we   = c;
      e.pht_addr = c ? idx : 8'd0;
      e.pht_data = 2'b00;
      if (c) begin
        cnt = int'(ref_pht[idx]);
        cnt = t ? ((cnt == 3) ? 3 : cnt + 1) : ((cnt == 0) ? 0 : cnt - 1);
        ref_pht[idx] = 2'(cnt);
        e.pht_data = ref_pht[idx];
        ref_ghr = {ref_ghr[6:0], t};
      end
      exp_q.push_back(e);
    end else begin
      chk("pht_re_idle", 66'(pht_re), 66'(0));
    end
    if (clr) begin
      ref_ghr = 8'd0;
      start_sweep();
    end else if (!ref_run) begin
      sweep_n++;
      if (sweep_n == 1024) ref_run = 1'b1;
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    clr_req   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic poke(input logic [7:0] a, input logic [1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_pht[a] = d;
    idle(1);
    pl_en = 1'b0;
  endtask

  // Monitor: every table write must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      chk("rst_strobes", 66'({btb_we, pht_we}), 66'(0));
    end else if (btb_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_btb_we", 66'(btb_we), 66'(0));
      end else begin
        e = exp_q.pop_front();
        chk("btb_waddr", 66'(btb_waddr), 66'(e.btb_addr));
        chk("btb_wdata", btb_wdata, e.btb_data);
        chk("pht_we", 66'(pht_we), 66'(e.pht_we));
        if (e.pht_we) begin
          chk("pht_waddr", 66'(pht_waddr), 66'(e.pht_addr));
          chk("pht_wdata", 66'(pht_wdata), 66'(e.pht_data));
        end
      end
    end else if (pht_we) begin
      chk("stray_pht_we", 66'(pht_we), 66'(0));
    end
  end

  initial begin
    logic [31:0] pc;
    logic        v, c, t;
    start_sweep();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1024);
    idle(2);

    // Conditional taken update against counter 01 from ghr 0.
    poke(8'h02, 2'b01);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_1008, 32'h0000_2000, 1'b0);
    idle(1);
    chk("t2_ghr", 66'(ghr), 66'(8'h01));

    // Saturation at both ends.
    poke(8'h20, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, {22'd0, 8'h20 ^ ref_ghr, 2'b00}, 32'h0000_3000, 1'b0);
    poke(8'h30, 2'b11);
    cyc(1'b1, 1'b1, 1'b1, {22'd0, 8'h30 ^ ref_ghr, 2'b00}, 32'h0000_3100, 1'b0);

    // Back-to-back same index: second write must use the forwarded value.
    poke(8'h10, 2'b01);
    cyc(1'b1, 1'b1, 1'b1, {22'd0, 8'h10 ^ ref_ghr, 2'b00}, 32'h0000_4000, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, {22'd0, 8'h10 ^ ref_ghr, 2'b00}, 32'h0000_4400, 1'b0);

    // Unconditional update.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080, 1'b0);
    idle(2);

    // Randomized traffic, biased towards same-index collisions.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      c = ($urandom % 4) != 0;
      t = 1'($urandom % 2);
      pc = $urandom;
      if ($urandom % 2 == 0) pc[9:2] = ref_ghr ^ 8'($urandom_range(0, 3));
      cyc(v, c, t, pc, $urandom, 1'b0);
    end

    // clr_req with a pending S1 write and a coincident update.
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_5004, 32'h0000_6000, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_7008, 32'h0000_8000, 1'b1);
    idle(1024);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 1'($urandom % 2), $urandom, $urandom, 1'b0);

    // Reset in the middle of a sweep restarts it from index 0.
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(500);
    resetn = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    ref_ghr = 8'd0;
    start_sweep();
    resetn = 1'b1;
    idle(1024);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'($urandom % 2), 1'($urandom % 2), $urandom, $urandom, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_empty", 66'(exp_q.size()), 66'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
